// File: rtl/ic_bv_pkg.sv
//==============================================================================
// Module      : ic_bv_pkg
// Description : Shared types and helpers for the ic_* bit-vector checkers:
//               controller state encoding, all-ones constant builder and an
//               unsigned greater-than helper.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package ic_bv_pkg;

    // Controller states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Low w bits set; callers truncate to their own width (w <= 32)
    function automatic logic [31:0] all_ones(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Unsigned x > y; operands are zero-extended by the caller
    function automatic logic ugt_u(input logic [31:0] x, input logic [31:0] y);
        return (x > y);
    endfunction

endpackage

`default_nettype wire

// File: rtl/udiv_restore_step.sv
//==============================================================================
// Module      : udiv_restore_step
// Description : One combinational radix-2 restoring division iteration.
//               Shifts the next dividend bit into the partial remainder,
//               trial-subtracts the divisor and restores on borrow.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module udiv_restore_step #(
    parameter int W = 4
) (
    input  logic [W:0]   i_pr,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic [W:0]   o_pr,
    output logic         o_qbit
);

    logic [W:0] w_shift;
    logic [W:0] w_trial;
    logic       w_unused_pr_msb;

    // The partial remainder stays below the divisor, so its MSB is always
    // zero on entry and only the low W bits take part in the shift.
    assign w_unused_pr_msb = i_pr[W];

    // A negative trial (MSB set) means the divisor did not fit: restore
    assign w_shift = {i_pr[W-1:0], i_bit};
    assign w_trial = w_shift - {1'b0, i_div};
    assign o_qbit  = ~w_trial[W];
    assign o_pr    = w_trial[W] ? w_shift : w_trial;

endmodule

`default_nettype wire

// File: rtl/ic_bvugt_bvudiv_seq_checker.sv
//==============================================================================
// Module      : ic_bvugt_bvudiv_seq_checker
// Description : Sequential evaluator of (a bvudiv b) bvugt t with SMT-LIB
//               division semantics (x/0 = all-ones, x%0 = x). One restoring
//               divider step per cycle, then an unsigned compare.
//               Start/done handshake, one operation in flight.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ic_bvugt_bvudiv_seq_checker
    import ic_bv_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = $clog2(W+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] t,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         div_by_zero,
    output logic         ugt
);

    localparam logic [W-1:0]  c_ONES     = W'(all_ones(W));
    localparam logic [CW-1:0] c_CNT_INIT = CW'(W);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_t;
    logic [W:0]    r_pr;
    logic [W-1:0]  r_q;
    logic [CW-1:0] r_cnt;
    logic          r_dz;
    logic [W-1:0]  r_quot;
    logic [W-1:0]  r_rem;
    logic          r_ugt;
    logic          r_dz_out;
    logic          r_done;

    logic [W:0]    w_pr_next;
    logic          w_qbit;
    logic          w_ugt;
    logic          w_accept;
    logic          w_unused_pr_msb;

    udiv_restore_step #(
        .W (W)
    ) u_step (
        .i_pr   (r_pr),
        .i_bit  (r_q[W-1]),
        .i_div  (r_b),
        .o_pr   (w_pr_next),
        .o_qbit (w_qbit)
    );

    // On the zero-divisor path r_q already holds all-ones, so one compare
    // serves both paths.
    assign w_ugt           = ugt_u(32'(r_q), 32'(r_t));
    assign w_accept        = start && ready;
    assign w_unused_pr_msb = r_pr[W];

    // Controller, divider datapath and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_t      <= '0;
            r_pr     <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_dz     <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_ugt    <= 1'b0;
            r_dz_out <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_t     <= t;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (r_b == '0) begin
                        r_q     <= c_ONES;
                        r_pr    <= {1'b0, r_a};
                        r_dz    <= 1'b1;
                        r_state <= S_CMP;
                    end else begin
                        r_q     <= r_a;
                        r_pr    <= '0;
                        r_cnt   <= c_CNT_INIT;
                        r_dz    <= 1'b0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_pr  <= w_pr_next;
                    r_q   <= {r_q[W-2:0], w_qbit};
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_quot   <= r_q;
                    r_rem    <= r_pr[W-1:0];
                    r_ugt    <= w_ugt;
                    r_dz_out <= r_dz;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decoded from state only
    always_comb begin
        ready = (r_state == S_IDLE) || (r_state == S_DONE);
        busy  = (r_state == S_LOAD) || (r_state == S_DIV) || (r_state == S_CMP);
    end

    assign done        = r_done;
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dz_out;
    assign ugt         = r_ugt;

endmodule

`default_nettype wire

// File: tb/tb_ic_bvugt_bvudiv_seq_checker.sv
//==============================================================================
// Module      : tb_ic_bvugt_bvudiv_seq_checker
// Description : Scoreboard bench for ic_bvugt_bvudiv_seq_checker (W=4).
//               Driver pushes expected results; monitor pops on done.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ic_bvugt_bvudiv_seq_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] t = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;
    logic         ugt;

    ic_bvugt_bvudiv_seq_checker #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .t           (t),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .ugt         (ugt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         g;
        int           issue_cyc;
        int           lat;
        logic [W-1:0] oa;
        logic [W-1:0] ob;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_done_cyc = -1;
    int   prev_done_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding entry
    always @(negedge clk) begin
        if (!rst && done) begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_e = sb.pop_front();
                chk("quot", 32'(quot), 32'(m_e.q));
                chk("rem", 32'(rem), 32'(m_e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(m_e.dz));
                chk("ugt", 32'(ugt), 32'(m_e.g));
                chk("latency", cyc - m_e.issue_cyc, m_e.lat);
                if (m_e.ob != '0) begin
                    chk("invariant_qbr", int'(quot) * int'(m_e.ob) + int'(rem), int'(m_e.oa));
                    chk("invariant_rltb", 32'(rem < m_e.ob), 1);
                end
            end
        end
    end

    // Issue one operation at the next ready negedge and record its expectation.
    // Latency counts cycles from the issuing cycle to the done cycle:
    // LOAD + W*DIV + CMP + DONE = W+3, or LOAD + CMP + DONE = 3 for b=0.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] it,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eg);
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
        a     = ia;
        b     = ib;
        t     = it;
        start = 1'b1;
        sb.push_back('{eq, er, edz, eg, cyc, (ib == '0) ? 3 : W + 3, ia, ib});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == '0) ? {W{1'b1}} : x / y;
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == '0) ? x : x % y;
    endfunction

    // Watchdog: never hang
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    int saved_done;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quot", 32'(quot), 0);
        chk("rst_rem", 32'(rem), 0);
        chk("rst_dz_ugt", {30'd0, div_by_zero, ugt}, 0);

        // Directed vectors, hand-computed
        issue(4'd13, 4'd3, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        wait_drain();
        issue(4'd9, 4'd0, 4'd14, 4'd15, 4'd9, 1'b1, 1'b1);
        wait_drain();
        issue(4'd9, 4'd0, 4'd15, 4'd15, 4'd9, 1'b1, 1'b0);
        wait_drain();
        issue(4'd5, 4'd7, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        wait_drain();
        issue(4'd15, 4'd1, 4'd14, 4'd15, 4'd0, 1'b0, 1'b1);
        wait_drain();

        // Results hold in IDLE after DONE
        repeat (3) @(negedge clk);
        chk("hold_quot", 32'(quot), 15);
        chk("hold_ugt", 32'(ugt), 1);
        chk("hold_ready", 32'(ready), 1);

        // Back-to-back: start held high, second set accepted in DONE
        issue(4'd13, 4'd3, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        start = 1'b1;
        a = 4'd12;
        b = 4'd4;
        t = 4'd3;
        issue(4'd12, 4'd4, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0);
        wait_drain();
        chk("b2b_done_gap", last_done_cyc - prev_done_cyc, 7);

        // Reset in the third cycle after accept (second DIV cycle)
        issue(4'd13, 4'd3, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        saved_done = last_done_cyc;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_outs", {22'd0, quot, rem, div_by_zero, ugt}, 0);
        repeat (10) @(negedge clk);
        chk("midrst_no_done", last_done_cyc, saved_done);
        issue(4'd5, 4'd7, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        wait_drain();

        // Exhaustive sweep with ignored start pulses and input noise while busy
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int it = 0; it < 16; it++) begin
                    issue(4'(ia), 4'(ib), 4'(it),
                          ref_q(4'(ia), 4'(ib)), ref_r(4'(ia), 4'(ib)),
                          (ib == 0), (ref_q(4'(ia), 4'(ib)) > 4'(it)));
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk);
                        if (busy) begin
                            start = 1'($urandom_range(0, 1));
                            a = 4'($urandom);
                            b = 4'($urandom);
                            t = 4'($urandom);
                        end else begin
                            start = 1'b0;
                            break;
                        end
                    end
                    start = 1'b0;
                end
            end
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
